risc_controller: RTL and testbench

- Instruction sequencer for the VeriRISC core. It sits directly upstream of the program counter and drives its load and enable pins through ld_pc and inc_pc.
- It also drives memory read/write, instruction-register load, accumulator load and data-bus enable.
- It steps through a fixed 8-phase cycle per instruction, decoding the 3-bit opcode held in the IR and the ALU zero flag.

---
 rtl/risc_controller_pkg.sv | 50 +++++
 rtl/risc_controller_if.sv | 30 +++
 rtl/risc_controller.sv | 120 ++++++++++++
 tb/tb_risc_controller.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/risc_controller_pkg.sv
// Shared VeriRISC definitions: opcodes, sequencer phases, control word.
// Imported by the controller, and by the ALU and IR blocks.
// Pure declarations; no logic, no timing.
package risc_pkg;

  // The ISA fixes the opcode field at three bits.
  localparam int OP_WIDTH = 3;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Full set of controller strobes, kept together so the decode can
  // clear everything with a single default.
  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic halt;
    logic data_e;
    logic ld_ac;
    logic wr;
  } ctrl_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath strobe bundle.
// master: the sequencer (drives strobes, reads opcode/zero).
// slave: the datapath side (IR, ALU, PC, memory).
interface risc_controller_if;
  import risc_pkg::*;

  logic [OP_WIDTH-1:0] opcode;
  logic                zero;
  logic                sel;
  logic                rd;
  logic                ld_ir;
  logic                inc_pc;
  logic                ld_pc;
  logic                halt;
  logic                data_e;
  logic                ld_ac;
  logic                wr;
  logic [2:0]          phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
  );

endinterface

// File: rtl/risc_controller.sv
// VeriRISC instruction sequencer: fixed 8-phase cycle per instruction.
// Strobes are combinational from the current phase (same-cycle decode).
// No backpressure; HLT parks the sequencer in OP_ADDR until reset when sticky.
module risc_controller #(
  parameter int OP_WIDTH    = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  risc_controller_if.master bus
);
  import risc_pkg::*;

  // The opcode comes straight from the IR, which only changes on ld_ir
  // phases, so it is stable through OP_ADDR..STORE and is not re-registered.
  logic [OP_WIDTH-1:0] op_raw;
  opcode_t             op;
  logic                aluop;

  assign op_raw = bus.opcode;
  assign op     = opcode_t'(op_raw);
  assign aluop  = is_aluop(op);

  phase_t phase_q;
  phase_t phase_d;
  logic   halted_q;
  logic   halted_d;
  ctrl_t  ctl;

  // Phase and halted-flag state; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: advance every edge, except freeze in OP_ADDR on a sticky HLT.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (HALT_STICKY && (phase_q == OP_ADDR) && (op == HLT)) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
    end
  end

  // Strobe decode per phase; a halted core drives only halt.
  always_comb begin
    ctl = '0;
    unique case (phase_q)
      INST_ADDR: begin
        ctl.sel = 1'b1;
      end
      INST_FETCH: begin
        ctl.sel = 1'b1;
        ctl.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        ctl.sel   = 1'b1;
        ctl.rd    = 1'b1;
        ctl.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        ctl.inc_pc = 1'b1;
        ctl.halt   = (op == HLT);
      end
      OP_FETCH: begin
        ctl.rd = aluop;
      end
      ALU_OP: begin
        // SKZ skips the next instruction by giving the PC a second increment.
        ctl.rd     = aluop;
        ctl.inc_pc = (op == SKZ) && bus.zero;
        ctl.ld_pc  = (op == JMP);
      end
      STORE: begin
        // JMP reloads the PC a second time with the same target.
        ctl.rd     = aluop;
        ctl.ld_ac  = aluop;
        ctl.ld_pc  = (op == JMP);
        ctl.wr     = (op == STO);
        ctl.data_e = (op == STO);
      end
      default: begin
        ctl = '0;
      end
    endcase
    if (halted_q) begin
      ctl      = '0;
      ctl.halt = 1'b1;
    end
  end

  assign bus.sel    = ctl.sel;
  assign bus.rd     = ctl.rd;
  assign bus.ld_ir  = ctl.ld_ir;
  assign bus.inc_pc = ctl.inc_pc;
  assign bus.ld_pc  = ctl.ld_pc;
  assign bus.halt   = ctl.halt;
  assign bus.data_e = ctl.data_e;
  assign bus.ld_ac  = ctl.ld_ac;
  assign bus.wr     = ctl.wr;
  assign bus.phase  = phase_q;

  // The PC counter must never be told to count and load at once.
  a_pc_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ctl.inc_pc && ctl.ld_pc));

  // Memory writes always come with the accumulator driving the bus.
  a_wr_needs_data_e: assert property (@(posedge clk) disable iff (rst)
    (!ctl.wr || ctl.data_e));

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller with a queue-based scoreboard.
// Vector bit order: sel rd ld_ir | inc_pc ld_pc halt | data_e ld_ac wr
module tb_risc_controller;

  typedef logic [8:0] vec_t;

  typedef struct {
    logic [2:0] ph;
    vec_t       v;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  exp_t exp_q[$];
  logic [7:0] pc;

  vec_t head [4] = '{9'b100_000_000, 9'b110_000_000, 9'b111_000_000, 9'b111_000_000};

  risc_controller_if bus ();

  risc_controller #(.OP_WIDTH(3), .HALT_STICKY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t outs();
    return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.halt,
            bus.data_e, bus.ld_ac, bus.wr};
  endfunction

  function automatic void check(input string tag, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endfunction

  // Monitor: every cycle that has an expectation queued is compared mid-cycle.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, {bus.phase, outs()}, {e.ph, e.v});
    end
  end

  // One full instruction; called with the DUT in phase 0, returns in phase 0.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [7:0] operand, input vec_t v4, input vec_t v5,
                           input vec_t v6, input vec_t v7,
                           input logic [7:0] pc_start, input logic [7:0] pc_exp);
    vec_t v;
    bus.opcode = op;
    bus.zero   = z;
    pc         = pc_start;
    for (int p = 0; p < 8; p++) begin
      case (p)
        4: v = v4;
        5: v = v5;
        6: v = v6;
        7: v = v7;
        default: v = head[p];
      endcase
      exp_q.push_back('{ph: 3'(p), v: v, tag: $sformatf("%s_p%0d", name, p)});
      // Program counter model, clocked by this phase's strobes.
      if (bus.ld_pc) pc = operand;
      else if (bus.inc_pc) pc = pc + 8'd1;
      @(posedge clk); #1;
    end
    check({name, "_pc"}, {4'd0, pc}, {4'd0, pc_exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    pc         = 8'h00;
    rst        = 1'b1;
    bus.opcode = 3'd5;
    bus.zero   = 1'b0;
    #3;
    check("reset_state", {bus.phase, outs()}, {3'd0, 9'b100_000_000});
    @(posedge clk); #2;
    rst = 1'b0;

    run_instr("lda", 3'd5, 1'b0, 8'h00, 9'b000_100_000, 9'b010_000_000,
              9'b010_000_000, 9'b010_000_010, 8'h03, 8'h04);
    run_instr("skz_z1", 3'd1, 1'b1, 8'h00, 9'b000_100_000, 9'b000_000_000,
              9'b000_100_000, 9'b000_000_000, 8'h0A, 8'h0C);
    run_instr("skz_z0", 3'd1, 1'b0, 8'h00, 9'b000_100_000, 9'b000_000_000,
              9'b000_000_000, 9'b000_000_000, 8'h0A, 8'h0B);
    run_instr("jmp", 3'd7, 1'b0, 8'h1F, 9'b000_100_000, 9'b000_000_000,
              9'b000_010_000, 9'b000_010_000, 8'h05, 8'h1F);
    run_instr("sto", 3'd6, 1'b0, 8'h00, 9'b000_100_000, 9'b000_000_000,
              9'b000_000_000, 9'b000_000_101, 8'h10, 8'h11);
    run_instr("add_z1", 3'd2, 1'b1, 8'h00, 9'b000_100_000, 9'b010_000_000,
              9'b010_000_000, 9'b010_000_010, 8'h20, 8'h21);

    // Abort an LDA in phase 5 with an asynchronous reset between edges.
    bus.opcode = 3'd5;
    bus.zero   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_phase", {9'd0, bus.phase}, {9'd0, 3'd5});
    #2 rst = 1'b1;
    #1;
    check("async_rst", {bus.phase, outs()}, {3'd0, 9'b100_000_000});
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_phase", {bus.phase, outs()}, {3'd1, 9'b110_000_000});
    repeat (7) @(posedge clk);
    #1;

    // Sticky HLT: reaches OP_ADDR and parks there.
    bus.opcode = 3'd0;
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back('{ph: 3'(p), v: (p == 4) ? 9'b000_101_000 : head[p],
                        tag: $sformatf("hlt_p%0d", p)});
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back('{ph: 3'd4, v: 9'b000_001_000, tag: $sformatf("halted_%0d", i)});
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("halt_rst", {bus.phase, outs()}, {3'd0, 9'b100_000_000});
    #2 rst = 1'b0;
    bus.opcode = 3'd5;
    @(posedge clk); #1;
    check("halt_rst_resume", {9'd0, bus.phase}, {9'd0, 3'd1});

    #10;
    check("sb_drain", 12'(exp_q.size()), 12'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
